// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares the async-FIFO write port
// among N_REQ write-domain producers. Each grant covers a burst of up to
// MAX_BURST words. FIFO full stalls the burst without releasing the grant.
//
// Ports:
//   wclk, wrst      write clock, asynchronous active-high reset
//   req, din        per-producer request/valid and packed data
//                   (producer i at din[i*DATA_W +: DATA_W])
//   full            FIFO full from the write-pointer logic
//   ready           per-producer accept strobe (combinational)
//   gnt             registered one-hot grant, all zero when idle
//   wr_enable_fifo  FIFO write enable (combinational)
//   wr_data         FIFO write data (combinational mux on gnt)
//   busy            high while in the BURST state
//
// Optional build macro FIFO_WR_ARB_STATS_EN adds these ports:
//   stat_sel        selects the producer whose counter is read
//   stat_clr        synchronously clears all counters
//   stat_cnt        saturating count of words accepted from stat_sel
module fifo_wr_arbiter #(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                        wclk,
   input  logic                        wrst,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*DATA_W-1:0]     din,
   input  logic                        full,
`ifdef FIFO_WR_ARB_STATS_EN
   input  logic [$clog2(N_REQ)-1:0]    stat_sel,
   input  logic                        stat_clr,
   output logic [15:0]                 stat_cnt,
`endif
   output logic [N_REQ-1:0]            ready,
   output logic [N_REQ-1:0]            gnt,
   output logic                        wr_enable_fifo,
   output logic [DATA_W-1:0]           wr_data,
   output logic                        busy
);

   localparam int unsigned PTR_W = $clog2(N_REQ);
   localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

   typedef enum logic [0:0] {ST_IDLE, ST_BURST} state_e;

   state_e             state_q,     state_d;
   logic [N_REQ-1:0]   gnt_q,       gnt_d;
   logic [PTR_W-1:0]   last_ptr_q,  last_ptr_d;
   logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

   logic               pick_vld;
   logic [PTR_W-1:0]   pick_idx;
   logic [PTR_W-1:0]   cand;
   logic               own_req;
   logic               accept;
   logic               release_now;

   // Write-side strobes come straight from the registered grant.
   assign ready          = gnt_q & req & {N_REQ{~full}};
   assign wr_enable_fifo = |ready;
   assign accept         = wr_enable_fifo;
   assign own_req        = |(gnt_q & req);
   assign gnt            = gnt_q;
   assign busy           = (state_q == ST_BURST);

   // Data mux: gnt_q is one-hot or zero, so an AND-OR tree suffices.
   always_comb begin
      wr_data = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (gnt_q[i]) begin
            wr_data = wr_data | din[i*DATA_W +: DATA_W];
         end
      end
   end

   // Round-robin search from last_ptr+1; k == N_REQ lands on the current
   // owner, so it only wins again when nobody else is requesting.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         cand = PTR_W'((32'(last_ptr_q) + k) % N_REQ);
         if (!pick_vld && req[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   assign release_now = (accept && (burst_cnt_q == CNT_W'(MAX_BURST - 1))) || !own_req;

   // Next-state: grant on request in IDLE, re-arbitrate in place on release.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      last_ptr_d  = last_ptr_q;
      burst_cnt_d = burst_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               state_d     = ST_BURST;
               gnt_d       = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
               last_ptr_d  = pick_idx;
               burst_cnt_d = '0;
            end
         end
         ST_BURST: begin
            if (release_now) begin
               burst_cnt_d = '0;
               if (pick_vld) begin
                  gnt_d      = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                  last_ptr_d = pick_idx;
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = '0;
               end
            end else if (accept) begin
               burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d     = ST_IDLE;
            gnt_d       = '0;
            burst_cnt_d = '0;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         state_q     <= ST_IDLE;
         gnt_q       <= '0;
         last_ptr_q  <= PTR_W'(N_REQ - 1);
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         last_ptr_q  <= last_ptr_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   logic [15:0] acc_cnt_q   [N_REQ];
   logic [15:0] acc_cnt_d   [N_REQ];
   logic [15:0] stall_cnt_q [N_REQ];
   logic [15:0] stall_cnt_d [N_REQ];

   // Saturating per-producer accept and full-stall counters.
   always_comb begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
         acc_cnt_d[i]   = acc_cnt_q[i];
         stall_cnt_d[i] = stall_cnt_q[i];
         if (stat_clr) begin
            acc_cnt_d[i]   = '0;
            stall_cnt_d[i] = '0;
         end else begin
            if (ready[i] && (acc_cnt_q[i] != 16'hFFFF)) begin
               acc_cnt_d[i] = acc_cnt_q[i] + 16'd1;
            end
            if (gnt_q[i] && req[i] && full && (stall_cnt_q[i] != 16'hFFFF)) begin
               stall_cnt_d[i] = stall_cnt_q[i] + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         for (int unsigned i = 0; i < N_REQ; i++) begin
            acc_cnt_q[i]   <= '0;
            stall_cnt_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < N_REQ; i++) begin
            acc_cnt_q[i]   <= acc_cnt_d[i];
            stall_cnt_q[i] <= stall_cnt_d[i];
         end
      end
   end

   assign stat_cnt = acc_cnt_q[stat_sel];
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios plus sticky random
// traffic, checked against a burst/round-robin reference model. Expected
// FIFO writes are queued at stimulus time and popped by a monitor whenever
// the DUT raises wr_enable_fifo.
module tb_fifo_wr_arbiter;

   localparam int unsigned N_REQ     = 4;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned MAX_BURST = 4;

   logic                    wclk = 1'b0;
   logic                    wrst = 1'b1;
   logic [N_REQ-1:0]        req  = '0;
   logic [N_REQ*DATA_W-1:0] din  = '0;
   logic                    full = 1'b0;
   logic [N_REQ-1:0]        ready;
   logic [N_REQ-1:0]        gnt;
   logic                    wr_enable_fifo;
   logic [DATA_W-1:0]       wr_data;
   logic                    busy;
`ifdef FIFO_WR_ARB_STATS_EN
   logic [1:0]              stat_sel = '0;
   logic                    stat_clr = 1'b0;
   logic [15:0]             stat_cnt;
`endif

   fifo_wr_arbiter #(
      .N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
   ) dut (
      .wclk(wclk),
      .wrst(wrst),
      .req(req),
      .din(din),
      .full(full),
`ifdef FIFO_WR_ARB_STATS_EN
      .stat_sel(stat_sel),
      .stat_clr(stat_clr),
      .stat_cnt(stat_cnt),
`endif
      .ready(ready),
      .gnt(gnt),
      .wr_enable_fifo(wr_enable_fifo),
      .wr_data(wr_data),
      .busy(busy)
   );

   always #5 wclk = ~wclk;

   int vectors     = 0;
   int miscompares = 0;

   logic [DATA_W-1:0] exp_data_q[$];
   int                exp_idx_q[$];

   // Reference model: current owner (-1 = none), words taken this grant,
   // last granted index, and accepted-word totals per producer.
   int m_owner = -1;
   int m_taken = 0;
   int m_last  = N_REQ - 1;
   int m_acc [N_REQ];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [N_REQ-1:0] r, input int last);
      for (int k = 1; k <= N_REQ; k++) begin
         int i;
         i = (last + k) % N_REQ;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [N_REQ-1:0] onehot(input int idx);
      logic [N_REQ-1:0] v;
      v = '0;
      if (idx >= 0) v[idx] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_taken = 0;
      m_last  = N_REQ - 1;
      for (int i = 0; i < N_REQ; i++) m_acc[i] = 0;
   endtask

   // Drive one cycle of inputs, queue the expected write and advance the model.
   task automatic apply(input logic [N_REQ-1:0] r, input logic f);
      int  w;
      bit  acc;
      req  = r;
      full = f;
      for (int i = 0; i < N_REQ; i++) din[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      if (m_owner < 0) begin
         w = rr_pick(r, m_last);
         if (w >= 0) begin
            m_owner = w;
            m_last  = w;
            m_taken = 0;
         end
      end else begin
         acc = r[m_owner] && !f;
         if (acc) begin
            exp_data_q.push_back(din[m_owner*DATA_W +: DATA_W]);
            exp_idx_q.push_back(m_owner);
            m_taken++;
            if (m_acc[m_owner] < 65535) m_acc[m_owner]++;
         end
         if ((acc && m_taken == MAX_BURST) || !r[m_owner]) begin
            w = rr_pick(r, m_last);
            if (w >= 0) begin
               m_owner = w;
               m_last  = w;
               m_taken = 0;
            end else begin
               m_owner = -1;
            end
         end
      end
   endtask

   task automatic step(input logic [N_REQ-1:0] r, input logic f);
      @(posedge wclk);
      #1;
      chk("gnt", 32'(gnt), 32'(onehot(m_owner)));
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      apply(r, f);
   endtask

   task automatic do_reset(input logic [N_REQ-1:0] r);
      @(posedge wclk);
      #1;
      wrst = 1'b1;
      req  = r;
      full = 1'b0;
      #1;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_ready", 32'(ready), 32'h0);
      chk("rst_wr_enable", 32'(wr_enable_fifo), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_pending_writes", 32'(exp_data_q.size()), 32'h0);
      exp_data_q.delete();
      exp_idx_q.delete();
      model_reset();
      repeat (2) @(posedge wclk);
      @(negedge wclk);
      wrst = 1'b0;
      apply(r, 1'b0);
   endtask

   // Monitor: every DUT write must match the oldest expected write.
   always @(negedge wclk) begin : monitor
      logic [DATA_W-1:0] d;
      int                idx;
      if (!wrst && wr_enable_fifo) begin
         if (exp_data_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got data 0x%0h ready 0x%0h expected no write at %0t",
                     wr_data, ready, $time);
         end else begin
            d   = exp_data_q.pop_front();
            idx = exp_idx_q.pop_front();
            chk("wr_data", 32'(wr_data), 32'(d));
            chk("ready", 32'(ready), 32'(onehot(idx)));
         end
      end
   end

   initial begin
      logic [N_REQ-1:0] r;
      logic             f;
      model_reset();

      // Reset with every producer requesting; producer 0 wins first.
      do_reset(4'b1111);
      step(4'b1111, 1'b0);
      chk("first_gnt", 32'(gnt), 32'h1);

      // Fairness: all requesting, bursts of MAX_BURST rotate 0,1,2,3,0.
      repeat (20) step(4'b1111, 1'b0);
      repeat (3)  step(4'b0000, 1'b0);

      // Early drop: producer 2 gives two words then releases to IDLE.
      repeat (3) step(4'b0100, 1'b0);
      repeat (2) step(4'b0000, 1'b0);
      chk("drop_gnt_idle", 32'(gnt), 32'h0);
      chk("drop_busy_idle", 32'(busy), 32'h0);
      step(4'b0010, 1'b0);
      step(4'b0010, 1'b0);
      chk("next_gnt_p1", 32'(gnt), 32'h2);

      // Backpressure: full for five cycles after word 1, grant must hold.
      for (int i = 0; i < 5; i++) begin
         step(4'b0010, 1'b1);
         chk("bp_gnt_hold", 32'(gnt), 32'h2);
         #4;
         chk("bp_no_write", 32'(wr_enable_fifo), 32'h0);
      end
      repeat (5) step(4'b0010, 1'b0);
      repeat (2) step(4'b0000, 1'b0);

      // Sole requester keeps the grant across burst boundaries.
      repeat (14) step(4'b1000, 1'b0);
      chk("sole_gnt", 32'(gnt), 32'h8);
      repeat (2) step(4'b0000, 1'b0);

      // Sticky random traffic with random backpressure and one mid-run reset.
      r = '0;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
         end
         f = ($urandom_range(0, 4) == 0);
         if (c == 300) begin
            do_reset(r);
         end else begin
            step(r, f);
         end
      end
      repeat (3) step(4'b0000, 1'b0);

`ifdef FIFO_WR_ARB_STATS_EN
      // Accept counters match the model, then clear to zero.
      for (int s = 0; s < N_REQ; s++) begin
         stat_sel = 2'(s);
         #1;
         chk("stat_cnt", 32'(stat_cnt), 32'(m_acc[s]));
      end
      @(posedge wclk);
      #1;
      stat_clr = 1'b1;
      @(posedge wclk);
      #1;
      stat_clr = 1'b0;
      for (int s = 0; s < N_REQ; s++) begin
         stat_sel = 2'(s);
         #1;
         chk("stat_cnt_clr", 32'(stat_cnt), 32'h0);
      end
`endif

      @(negedge wclk);
      #1;
      chk("writes_drained", 32'(exp_data_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
